sap_ram_mar: RTL and testbench
==============================

Name: sap_ram_mar

Overview:
- Parametrised successor of the SAP RAM/MAR pair: memory array plus memory address register in one block.
- Adds a synchronised, edge-detected programming-button write with optional MAR auto-increment, so a program can be keyed in word by word from the DIP switches.
- In run mode the block is a plain bus-side RAM with MAR load, write and tri-state-style output enable.

Parameters:
DATA_W, 8, data word width (memory width and bus width)
ADDR_W, 4, address width; depth = 2**ADDR_W words
AUTO_INC, 1, 1 = MAR increments after each programming write; 0 = MAR holds

Ports:
clk  input  1  system clock, rising-edge active
clear_n  input  1  asynchronous active-low reset
prog_mode  input  1  1 = programming mode (DIP switches), 0 = run mode (bus)
prog_addr  input  ADDR_W  DIP-switch address
prog_data  input  DATA_W  DIP-switch data
prog_addr_load  input  1  level; in programming mode, loads MAR from prog_addr each cycle
prog_write_btn  input  1  raw asynchronous write push-button, active high
bus_in  input  DATA_W  system bus value
load_mar_n  input  1  run mode: load MAR from bus_in[ADDR_W-1:0]
ram_in_n  input  1  run mode: write bus_in into mem[MAR]
ram_out_n  input  1  run mode: drive mem[MAR] onto bus_out
bus_out  output  DATA_W  read data; 0 when not enabled
bus_oe  output  1  1 when bus_out is valid and driving
mar_q  output  ADDR_W  current MAR value, for the address LEDs
prog_busy  output  1  programming FSM is not IDLE

Behaviour:
Reset (clear_n=0, asynchronous):
- mar_q=0, FSM=IDLE, synchroniser and edge flops=0.
- bus_oe=0, bus_out=0, prog_busy=0.
- Memory contents are not cleared and are retained across reset.

Button synchroniser:
- Two-flop synchroniser (s1, s2) plus a delay flop s3.
- rise = s2 & ~s3.
- Button high first sampled at edge k: s1=1 after k, s2=1 after k+1, rise asserted during the cycle after k+1.

Programming FSM (active only when prog_mode=1):
- IDLE: rise -> WRITE. Otherwise stay.
- WRITE: one cycle; at the closing edge mem[mar_q] <= prog_data. Next state is INC if AUTO_INC=1, else WAIT_REL.
- INC: one cycle; at the closing edge mar_q <= mar_q+1 modulo 2**ADDR_W (all-ones wraps to 0). Next state WAIT_REL.
- WAIT_REL: stay while s2=1; s2=0 -> IDLE. A held button therefore produces exactly one write.
- prog_busy=1 in WRITE, INC, WAIT_REL.
- prog_addr_load is honoured in IDLE and WAIT_REL only. It is ignored in WRITE and INC.
- prog_mode falling in any state: FSM -> IDLE at the next edge. A WRITE state that has already been entered completes its write on that same edge. A pending INC is dropped.

Run mode (prog_mode=0):
- FSM is held in IDLE; rise is ignored.
- load_mar_n=0: mar_q <= bus_in[ADDR_W-1:0] at the edge.
- ram_in_n=0: mem[mar_q] <= bus_in at the edge.
- If load_mar_n and ram_in_n are both asserted in the same cycle, the write uses the pre-edge MAR and the MAR loads the new value.
- ram_out_n=0: bus_oe=1 and bus_out=mem[mar_q], combinational from the registered MAR (same-cycle read).
- If ram_in_n and ram_out_n are both asserted, bus_out shows the old data in that cycle and the new data from the next cycle.

Programming mode outputs:
- bus_oe=0 and bus_out=0 regardless of ram_out_n.
- All bus-side controls are ignored.

Data path:
- No arithmetic other than the MAR increment.
- bus_in bits above ADDR_W are ignored for MAR loads.

Test Plan:
- Reset, then run mode: load_mar_n=0 with bus_in=8'hFA -> mar_q=4'hA. Then ram_in_n=0 with bus_in=8'hF7, then ram_out_n=0 -> bus_oe=1, bus_out=8'hF7.
- Programming mode, AUTO_INC=1: prog_addr_load with prog_addr=4'hF, then prog_data=8'hCF and button held 20 cycles -> exactly one write. mem[F]=8'hCF; mar_q wraps to 0 three edges after rise; prog_busy clears after release.
- Programming mode, AUTO_INC=0: two button presses with prog_data 8'h11 then 8'h22 at MAR=3 -> mem[3]=8'h22, mar_q stays 3.
- Button pulse shorter than one clock period that straddles no edge -> no write, FSM stays IDLE. Button high for 1 sampled edge -> one write.
- Run mode, simultaneous load_mar_n=0 and ram_in_n=0 with MAR=2 and bus_in=8'h35 -> mem[2]=8'h35, mar_q=5. In the same cycle ram_out_n=0 shows the old mem[2].
- Assert clear_n=0 asynchronously mid-INC -> mar_q=0 and FSM IDLE immediately (no clock needed). The word written in the preceding WRITE is retained.
- prog_mode dropped during WAIT_REL with ram_out_n=0 -> FSM IDLE next edge; bus_oe=1 once prog_mode=0.

Source files
------------

// File: rtl/sap_ram_mar.sv
// SAP RAM with its memory address register, plus a synchronised push-button path
// for keying a program in word by word from the DIP switches.
module sap_ram_mar #(
   parameter int unsigned DATA_W   = 8,
   parameter int unsigned ADDR_W   = 4,
   parameter int unsigned AUTO_INC = 1
) (
   input  logic              clk,
   input  logic              clear_n,
   input  logic              prog_mode,
   input  logic [ADDR_W-1:0] prog_addr,
   input  logic [DATA_W-1:0] prog_data,
   input  logic              prog_addr_load,
   input  logic              prog_write_btn,
   input  logic [DATA_W-1:0] bus_in,
   input  logic              load_mar_n,
   input  logic              ram_in_n,
   input  logic              ram_out_n,
   output logic [DATA_W-1:0] bus_out,
   output logic              bus_oe,
   output logic [ADDR_W-1:0] mar_q,
   output logic              prog_busy
);

   localparam int unsigned DEPTH = 2 ** ADDR_W;

   localparam logic [1:0] ST_IDLE     = 2'd0;
   localparam logic [1:0] ST_WRITE    = 2'd1;
   localparam logic [1:0] ST_INC      = 2'd2;
   localparam logic [1:0] ST_WAIT_REL = 2'd3;

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [ADDR_W-1:0] r_mar;
   logic [ADDR_W-1:0] w_mar_d;
   logic [1:0]        r_state;
   logic [1:0]        w_state_d;
   logic              r_s1;
   logic              r_s2;
   logic              r_s3;
   logic              w_rise;
   logic              w_prog_we;
   logic              w_bus_we;

   // s1/s2 resynchronise the raw button; s3 delays s2 for rising-edge detection
   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         r_s1 <= 1'b0;
         r_s2 <= 1'b0;
         r_s3 <= 1'b0;
      end else begin
         r_s1 <= prog_write_btn;
         r_s2 <= r_s1;
         r_s3 <= r_s2;
      end
   end

   assign w_rise = r_s2 & ~r_s3;

   always_comb begin
      w_state_d = r_state;
      if (!prog_mode) begin
         w_state_d = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE:     if (w_rise) w_state_d = ST_WRITE;
            ST_WRITE:    w_state_d = (AUTO_INC != 0) ? ST_INC : ST_WAIT_REL;
            ST_INC:      w_state_d = ST_WAIT_REL;
            ST_WAIT_REL: if (!r_s2) w_state_d = ST_IDLE;
            default:     w_state_d = ST_IDLE;
         endcase
      end
   end

   // Leaving programming mode mid-INC drops the increment
   always_comb begin
      w_mar_d = r_mar;
      if (prog_mode) begin
         if (r_state == ST_INC) begin
            w_mar_d = r_mar + 1'b1;
         end else if (prog_addr_load &&
                      (r_state == ST_IDLE || r_state == ST_WAIT_REL)) begin
            w_mar_d = prog_addr;
         end
      end else if (!load_mar_n) begin
         w_mar_d = bus_in[ADDR_W-1:0];
      end
   end

   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         r_state <= ST_IDLE;
         r_mar   <= '0;
      end else begin
         r_state <= w_state_d;
         r_mar   <= w_mar_d;
      end
   end

   // A WRITE already entered completes even if prog_mode drops that cycle
   assign w_prog_we = (r_state == ST_WRITE);
   assign w_bus_we  = ~prog_mode & ~ram_in_n;

   // Memory has no reset so contents survive clear_n
   always_ff @(posedge clk) begin
      if (w_prog_we) begin
         r_mem[r_mar] <= prog_data;
      end else if (w_bus_we) begin
         r_mem[r_mar] <= bus_in;
      end
   end

   assign bus_oe    = clear_n & ~prog_mode & ~ram_out_n;
   assign bus_out   = bus_oe ? r_mem[r_mar] : '0;
   assign mar_q     = r_mar;
   assign prog_busy = (r_state != ST_IDLE);

endmodule

// File: tb/tb_sap_ram_mar.sv
// Bench for sap_ram_mar: one AUTO_INC=1 and one AUTO_INC=0 instance on shared stimulus,
// checked against an array-based model of memory and MAR.
module tb_sap_ram_mar;

   localparam int unsigned DW = 8;
   localparam int unsigned AW = 4;

   logic          clk;
   logic          clear_n;
   logic          prog_mode;
   logic [AW-1:0] prog_addr;
   logic [DW-1:0] prog_data;
   logic          prog_addr_load;
   logic          prog_write_btn;
   logic [DW-1:0] bus_in;
   logic          load_mar_n;
   logic          ram_in_n;
   logic          ram_out_n;

   logic [DW-1:0] bus_out_a, bus_out_b;
   logic          bus_oe_a, bus_oe_b;
   logic [AW-1:0] mar_a, mar_b;
   logic          busy_a, busy_b;

   sap_ram_mar #(.DATA_W(DW), .ADDR_W(AW), .AUTO_INC(1)) u_dut_inc (
      .clk            (clk),
      .clear_n        (clear_n),
      .prog_mode      (prog_mode),
      .prog_addr      (prog_addr),
      .prog_data      (prog_data),
      .prog_addr_load (prog_addr_load),
      .prog_write_btn (prog_write_btn),
      .bus_in         (bus_in),
      .load_mar_n     (load_mar_n),
      .ram_in_n       (ram_in_n),
      .ram_out_n      (ram_out_n),
      .bus_out        (bus_out_a),
      .bus_oe         (bus_oe_a),
      .mar_q          (mar_a),
      .prog_busy      (busy_a)
   );

   sap_ram_mar #(.DATA_W(DW), .ADDR_W(AW), .AUTO_INC(0)) u_dut_hold (
      .clk            (clk),
      .clear_n        (clear_n),
      .prog_mode      (prog_mode),
      .prog_addr      (prog_addr),
      .prog_data      (prog_data),
      .prog_addr_load (prog_addr_load),
      .prog_write_btn (prog_write_btn),
      .bus_in         (bus_in),
      .load_mar_n     (load_mar_n),
      .ram_in_n       (ram_in_n),
      .ram_out_n      (ram_out_n),
      .bus_out        (bus_out_b),
      .bus_oe         (bus_oe_b),
      .mar_q          (mar_b),
      .prog_busy      (busy_b)
   );

   logic [DW-1:0] m_mem_a [16];
   logic [DW-1:0] m_mem_b [16];
   logic [AW-1:0] m_mar_a;
   logic [AW-1:0] m_mar_b;
   int            n_tests = 0;
   int            n_fail  = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One run-mode cycle: check outputs against the model, clock, then apply the rules
   task automatic run_cycle(input logic lm, input logic ri, input logic ro,
                            input logic [DW-1:0] bin);
      load_mar_n = lm;
      ram_in_n   = ri;
      ram_out_n  = ro;
      bus_in     = bin;
      #1;
      chk("run_oe_a", 32'(bus_oe_a), 32'(!ro));
      chk("run_oe_b", 32'(bus_oe_b), 32'(!ro));
      chk("run_out_a", 32'(bus_out_a), ro ? 32'd0 : 32'(m_mem_a[m_mar_a]));
      chk("run_out_b", 32'(bus_out_b), ro ? 32'd0 : 32'(m_mem_b[m_mar_b]));
      chk("run_mar_a", 32'(mar_a), 32'(m_mar_a));
      chk("run_mar_b", 32'(mar_b), 32'(m_mar_b));
      tick();
      if (!ri) begin
         m_mem_a[m_mar_a] = bin;
         m_mem_b[m_mar_b] = bin;
      end
      if (!lm) begin
         m_mar_a = bin[AW-1:0];
         m_mar_b = bin[AW-1:0];
      end
      load_mar_n = 1'b1;
      ram_in_n   = 1'b1;
      ram_out_n  = 1'b1;
   endtask

   task automatic prog_load(input logic [AW-1:0] addr);
      prog_addr      = addr;
      prog_addr_load = 1'b1;
      tick();
      prog_addr_load = 1'b0;
      m_mar_a = addr;
      m_mar_b = addr;
      chk("pload_mar_a", 32'(mar_a), 32'(addr));
      chk("pload_mar_b", 32'(mar_b), 32'(addr));
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((busy_a || busy_b) && n < 10) begin
         tick();
         n++;
      end
      chk("idle_a", 32'(busy_a), 32'd0);
      chk("idle_b", 32'(busy_b), 32'd0);
   endtask

   // A press of any length writes one word; AUTO_INC then advances the MAR
   task automatic press(input logic [DW-1:0] data, input int hold);
      prog_data      = data;
      prog_write_btn = 1'b1;
      repeat (hold) tick();
      prog_write_btn = 1'b0;
      repeat (2) tick();
      chk("press_busy_a", 32'(busy_a), 32'd1);
      chk("press_busy_b", 32'(busy_b), 32'd1);
      wait_idle();
      m_mem_a[m_mar_a] = data;
      m_mar_a          = m_mar_a + 1'b1;
      m_mem_b[m_mar_b] = data;
      chk("press_mar_a", 32'(mar_a), 32'(m_mar_a));
      chk("press_mar_b", 32'(mar_b), 32'(m_mar_b));
   endtask

   task automatic readback_all();
      logic [DW-1:0] b;
      for (int i = 0; i < 16; i++) begin
         b      = 8'($urandom);
         b[3:0] = 4'(i);
         run_cycle(1'b0, 1'b1, 1'b1, b);
         run_cycle(1'b1, 1'b1, 1'b0, 8'($urandom));
      end
   endtask

   initial begin
      logic [DW-1:0] old;
      logic [DW-1:0] d;
      clear_n        = 1'b1;
      prog_mode      = 1'b0;
      prog_addr      = '0;
      prog_data      = '0;
      prog_addr_load = 1'b0;
      prog_write_btn = 1'b0;
      bus_in         = '0;
      load_mar_n     = 1'b1;
      ram_in_n       = 1'b1;
      ram_out_n      = 1'b0;
      m_mar_a        = '0;
      m_mar_b        = '0;

      #2 clear_n = 1'b0;
      #1;
      chk("rst_mar_a", 32'(mar_a), 32'd0);
      chk("rst_busy_a", 32'(busy_a), 32'd0);
      chk("rst_oe_a", 32'(bus_oe_a), 32'd0);
      chk("rst_out_a", 32'(bus_out_a), 32'd0);
      chk("rst_oe_b", 32'(bus_oe_b), 32'd0);
      repeat (2) tick();
      ram_out_n = 1'b1;
      clear_n   = 1'b1;
      tick();

      // Directed run-mode load / write / read
      run_cycle(1'b0, 1'b1, 1'b1, 8'hFA);
      chk("tp1_mar", 32'(mar_a), 32'hA);
      run_cycle(1'b1, 1'b0, 1'b1, 8'hF7);
      ram_out_n = 1'b0;
      #1;
      chk("tp1_oe", 32'(bus_oe_a), 32'd1);
      chk("tp1_out", 32'(bus_out_a), 32'hF7);
      ram_out_n = 1'b1;
      tick();

      for (int i = 0; i < 16; i++) begin
         run_cycle(1'b0, 1'b1, 1'b1, 8'(i));
         run_cycle(1'b1, 1'b0, 1'b1, 8'($urandom));
      end

      for (int i = 0; i < 150; i++) begin
         run_cycle(1'($urandom), 1'($urandom_range(0, 2) != 0), 1'($urandom),
                   8'($urandom));
      end

      // Simultaneous MAR load and write, with read in the same cycle
      run_cycle(1'b0, 1'b1, 1'b1, 8'h02);
      old = m_mem_a[2];
      run_cycle(1'b0, 1'b0, 1'b0, 8'h35);
      chk("simul_mar", 32'(mar_a), 32'h5);
      run_cycle(1'b0, 1'b1, 1'b1, 8'h02);
      ram_out_n = 1'b0;
      #1;
      chk("simul_new", 32'(bus_out_a), 32'h35);
      chk("simul_changed", 32'(bus_out_a == old), 32'(old == 8'h35));
      ram_out_n = 1'b1;
      tick();

      // Programming mode: bus side is silent and ignored
      prog_mode = 1'b1;
      tick();
      ram_out_n  = 1'b0;
      load_mar_n = 1'b0;
      ram_in_n   = 1'b0;
      bus_in     = 8'h0C;
      #1;
      chk("prog_oe", 32'(bus_oe_a), 32'd0);
      chk("prog_out", 32'(bus_out_a), 32'd0);
      tick();
      chk("prog_busmar", 32'(mar_a), 32'(m_mar_a));
      ram_out_n  = 1'b1;
      load_mar_n = 1'b1;
      ram_in_n   = 1'b1;

      // Held button at the top address: one write, MAR wraps three edges after rise
      prog_load(4'hF);
      prog_data      = 8'hCF;
      prog_write_btn = 1'b1;
      tick();
      tick();
      chk("hold_rise_busy", 32'(busy_a), 32'd0);
      tick();
      chk("hold_write_busy", 32'(busy_a), 32'd1);
      chk("hold_write_mar", 32'(mar_a), 32'hF);
      tick();
      chk("hold_inc_mar", 32'(mar_a), 32'hF);
      tick();
      chk("hold_wrap_a", 32'(mar_a), 32'h0);
      chk("hold_noinc_b", 32'(mar_b), 32'hF);
      repeat (15) tick();
      chk("hold_busy", 32'(busy_a), 32'd1);
      chk("hold_mar", 32'(mar_a), 32'h0);
      prog_write_btn = 1'b0;
      wait_idle();
      m_mem_a[15] = 8'hCF;
      m_mem_b[15] = 8'hCF;
      m_mar_a     = 4'h0;

      // Two presses at MAR 3
      prog_load(4'h3);
      press(8'h11, 2);
      press(8'h22, 2);
      chk("noinc_mar_b", 32'(mar_b), 32'h3);

      // Pulse between edges is never sampled
      #2 prog_write_btn = 1'b1;
      #3 prog_write_btn = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("glitch_busy", 32'(busy_a), 32'd0);
      end
      chk("glitch_mar", 32'(mar_a), 32'(m_mar_a));

      press(8'h5A, 1);
      for (int i = 0; i < 6; i++) begin
         if ($urandom_range(0, 2) == 0) prog_load(4'($urandom));
         press(8'($urandom), int'($urandom_range(1, 5)));
      end

      prog_mode = 1'b0;
      tick();
      run_cycle(1'b0, 1'b1, 1'b1, 8'h03);
      ram_out_n = 1'b0;
      #1;
      chk("noinc_mem3_b", 32'(bus_out_b), 32'(m_mem_b[3]));
      ram_out_n = 1'b1;
      tick();
      readback_all();

      // Asynchronous clear during INC
      prog_mode = 1'b1;
      tick();
      prog_load(4'h7);
      d              = 8'($urandom);
      prog_data      = d;
      prog_write_btn = 1'b1;
      repeat (4) tick();
      chk("preclr_busy", 32'(busy_a), 32'd1);
      #2 clear_n = 1'b0;
      #1;
      chk("clr_mar_a", 32'(mar_a), 32'd0);
      chk("clr_busy_a", 32'(busy_a), 32'd0);
      chk("clr_busy_b", 32'(busy_b), 32'd0);
      prog_write_btn = 1'b0;
      repeat (2) tick();
      clear_n = 1'b1;
      tick();
      m_mem_a[7] = d;
      m_mem_b[7] = d;
      m_mar_a    = '0;
      m_mar_b    = '0;

      // prog_mode dropped in WAIT_REL with ram_out_n asserted
      d              = 8'($urandom);
      prog_data      = d;
      prog_write_btn = 1'b1;
      repeat (8) tick();
      m_mem_a[m_mar_a] = d;
      m_mar_a          = m_mar_a + 1'b1;
      m_mem_b[m_mar_b] = d;
      chk("drop_busy_a", 32'(busy_a), 32'd1);
      ram_out_n = 1'b0;
      #1;
      chk("drop_oe_prog", 32'(bus_oe_a), 32'd0);
      prog_mode = 1'b0;
      #1;
      chk("drop_oe_run", 32'(bus_oe_a), 32'd1);
      chk("drop_out_a", 32'(bus_out_a), 32'(m_mem_a[m_mar_a]));
      tick();
      chk("drop_idle_a", 32'(busy_a), 32'd0);
      chk("drop_idle_b", 32'(busy_b), 32'd0);
      ram_out_n      = 1'b1;
      prog_write_btn = 1'b0;
      repeat (3) tick();
      readback_all();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
